// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches words from imem and presents
// them to decode through an output register plus a one-entry skid.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic [31:0] word_q;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;
  logic        skid_valid;
  logic        drop;

  logic rsp_use;
  logic take;
  logic skid_next;
  logic pend;
  logic accept;

  always_comb begin
    rsp_use   = imem_rsp_valid && !drop;
    take      = !instr_valid || !stall;
    skid_next = take ? (skid_valid && rsp_use)
                     : (skid_valid || rsp_use);
    pend      = (state == S_WAIT) || drop;
    imem_req_valid = 1'b0;
    if (!rst && !redirect_valid) begin
      unique case (state)
        S_REQ:   imem_req_valid = !skid_valid && !drop;
        // Back-to-back issue when the returning word leaves the skid free
        S_WAIT:  imem_req_valid = imem_rsp_valid && !skid_next;
        default: imem_req_valid = 1'b0;
      endcase
    end
    accept = imem_req_valid && imem_req_ready;
  end

  assign imem_req_addr = pc;
  assign instruction   = instr_valid ? word_q : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      fetch_pc    <= RESET_PC;
      // A request accepted before reset still owes a response
      drop        <= pend && !imem_rsp_valid;
      skid_valid  <= 1'b0;
      skid_data   <= 32'h0;
      skid_pc     <= 32'h0;
      instr_valid <= 1'b0;
      instr_pc    <= 32'h0;
      word_q      <= NOP_INSTR;
      misaligned  <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      drop        <= pend && !imem_rsp_valid;
      skid_valid  <= 1'b0;
      instr_valid <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misaligned <= 1'b1;
        state      <= S_HALT;
      end else begin
        misaligned <= 1'b0;
        state      <= S_REQ;
      end
    end else begin
      if (drop && imem_rsp_valid) drop <= 1'b0;
      unique case (state)
        S_REQ:   if (accept) state <= S_WAIT;
        S_WAIT:  if (imem_rsp_valid && !accept) state <= S_REQ;
        default: state <= state;
      endcase
      if (accept) begin
        pc       <= pc + 32'd4;
        fetch_pc <= pc;
      end
      if (take) begin
        if (skid_valid) begin
          word_q      <= skid_data;
          instr_pc    <= skid_pc;
          instr_valid <= 1'b1;
        end else if (rsp_use) begin
          word_q      <= imem_rsp_data;
          instr_pc    <= fetch_pc;
          instr_valid <= 1'b1;
        end else begin
          instr_valid <= 1'b0;
        end
      end
      if (rsp_use && (!take || skid_valid)) begin
        skid_data <= imem_rsp_data;
        skid_pc   <= fetch_pc;
      end
      skid_valid <= skid_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random
// memory timing, stall and redirects against a stream-level model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misaligned;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h1357_9bd0;
  endfunction

  // memory model
  bit          pend = 0;
  logic [31:0] pend_addr;
  int          cnt = 0;
  int          rdy_pct = 100;
  int          dmin = 0;
  int          dmax = 0;
  // stream model
  bit          rst_v = 1;
  logic [31:0] exp_pc = 32'h0;
  bit          exp_mis = 0;
  bit          halted = 0;
  bit          post_redir = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_pc;
  logic [31:0] prev_ins;
  int          consumed = 0;

  task automatic sample();
    bit rsp_now;
    if (!instr_valid) check("nop", instruction, NOP);
    if (rst) begin
      check("rst_req", imem_req_valid, 0);
    end else begin
      check("mis", misaligned, exp_mis);
      if (post_redir || halted) check("flushed", instr_valid, 0);
      if (halted) check("halt_req", imem_req_valid, 0);
      if (redirect_valid) check("redir_req", imem_req_valid, 0);
      if (imem_req_valid) check("align", imem_req_addr[1:0], 0);
      if (prev_hold) begin
        check("hold_v", instr_valid, 1);
        check("hold_pc", instr_pc, prev_pc);
        check("hold_i", instruction, prev_ins);
      end
      if (instr_valid && !stall && !redirect_valid) begin
        check("pc", instr_pc, exp_pc);
        check("data", instruction, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
    rsp_now = imem_rsp_valid;
    if (rsp_now) pend = 0;
    else if (pend) cnt--;
    if (imem_req_valid && imem_req_ready) begin
      check("one_out", pend, 0);
      pend = 1;
      pend_addr = imem_req_addr;
      cnt = $urandom_range(dmax, dmin);
    end
    prev_hold  = instr_valid && stall && !redirect_valid && !rst;
    prev_pc    = instr_pc;
    prev_ins   = instruction;
    post_redir = redirect_valid && !rst;
    if (rst) begin
      exp_pc  = 32'h0;
      exp_mis = 0;
      halted  = 0;
    end else if (redirect_valid) begin
      exp_pc  = {redirect_pc[31:2], 2'b00};
      halted  = redirect_pc[1:0] != 2'b00;
      exp_mis = halted;
    end
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst            = rst_v;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = tgt;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    imem_rsp_valid = pend && (cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(pend_addr) : $urandom;
    @(negedge clk);
    sample();
  endtask

  task automatic wait_valid(string tag, logic [31:0] exp);
    int n = 0;
    do begin
      step(0, 0, 32'h0);
      n++;
    end while (!instr_valid && n < 40);
    check({tag, "_to"}, instr_valid, 1);
    check(tag, instr_pc, exp);
  endtask

  initial begin
    bit any_req;
    rst = 1;
    stall = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    imem_req_ready = 0;
    imem_rsp_valid = 0;
    imem_rsp_data = 0;

    rst_v = 1;
    step(0, 0, 32'h0);
    step(0, 0, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_ins", instruction, NOP);
    check("rst_pc", instr_pc, 0);
    check("rst_mis", misaligned, 0);

    // one-cycle memory, always ready
    rst_v = 0;
    step(0, 0, 32'h0);
    check("c0_req", imem_req_valid, 1);
    check("c0_addr", imem_req_addr, 32'h0);
    check("c0_v", instr_valid, 0);
    step(0, 0, 32'h0);
    check("c1_addr", imem_req_addr, 32'h4);
    check("c1_v", instr_valid, 0);
    step(0, 0, 32'h0);
    check("c2_addr", imem_req_addr, 32'h8);
    check("c2_v", instr_valid, 1);
    check("c2_pc", instr_pc, 32'h0);
    step(0, 0, 32'h0);
    check("c3_pc", instr_pc, 32'h4);

    // three stall cycles fill the skid
    step(1, 0, 32'h0);
    check("s1_pc", instr_pc, 32'h8);
    check("s1_req", imem_req_valid, 0);
    step(1, 0, 32'h0);
    check("s2_req", imem_req_valid, 0);
    step(1, 0, 32'h0);
    check("s3_req", imem_req_valid, 0);
    check("s3_pc", instr_pc, 32'h8);
    step(0, 0, 32'h0);
    step(0, 0, 32'h0);
    check("skid_pc", instr_pc, 32'hc);

    // redirect with a response outstanding
    dmin = 2;
    dmax = 2;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 32'h0);
      if (imem_req_valid && imem_req_ready) break;
    end
    step(0, 1, 32'h100);
    wait_valid("redir", 32'h100);

    // misaligned target halts fetch until an aligned redirect
    step(0, 1, 32'h102);
    step(0, 0, 32'h0);
    check("mis_set", misaligned, 1);
    any_req = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 32'h0);
      any_req |= imem_req_valid;
    end
    check("halt_noreq", any_req, 0);
    step(0, 1, 32'h200);
    step(0, 0, 32'h0);
    check("mis_clr", misaligned, 0);
    wait_valid("pc200", 32'h200);

    // PC wrap
    step(0, 1, 32'hffff_fffc);
    wait_valid("wrap0", 32'hffff_fffc);
    wait_valid("wrap1", 32'h0);

    // random memory timing, stall and redirects
    dmin = 0;
    dmax = 5;
    rdy_pct = 70;
    for (int i = 0; i < 4000; i++) begin
      bit          st;
      bit          rd;
      logic [31:0] tgt;
      st  = $urandom_range(99) < 30;
      rd  = $urandom_range(99) < 2;
      tgt = {$urandom_range(32'h3fff_ffff, 0), 2'b00};
      if ($urandom_range(99) < 15) tgt[1:0] = 2'($urandom_range(3, 1));
      if (halted && $urandom_range(99) < 10) begin
        rd = 1;
        tgt[1:0] = 2'b00;
      end
      step(st, rd, tgt);
    end
    check("progress", consumed > 300, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
